// File: rtl/multicycle_controller.sv
// Multicycle RV32 control FSM: Moore strobes decoded from state plus held instruction fields.
// Latency 3-5 cycles per instruction (+ memory waits); stalls in MEM_RD/MEM_WR until mem_ready_i.
module multicycle_controller #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [6:0]            op_i,
  input  logic [2:0]            funct3_i,
  input  logic                  funct7_5_i,
  input  logic                  eq_i,
  input  logic                  mem_ready_i,
  output logic                  ir_we_o,
  output logic                  pc_we_o,
  output logic                  reg_we_o,
  output logic                  data_mem_we_o,
  output logic [1:0]            pc_src_o,
  output logic [1:0]            result_src_o,
  output logic [3:0]            alu_control_o,
  output logic                  alu_src_o,
  output logic                  data_mem_byte_op_o,
  output logic                  instr_done_o,
  output logic                  illegal_o,
  output logic [DATA_WIDTH-1:0] instret_o
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
    WB_MEM, BRANCH, JUMP, JALR, LUI, ILLEGAL
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  state_t state, next_state;
  // EXEC_R/EXEC_I span two cycles: compute, then write back on the second.
  logic   exec_wb, exec_wb_next;
  logic   ir_we_c, pc_we_c, reg_we_c, dm_we_c, done_c;
  logic   is_load, mem_f3_ok, byte_sel;

  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7_5,
                                            input logic allow_sub);
    case (f3)
      3'b000:  alu_decode = (allow_sub && f7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = ALU_SLL;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      3'b100:  alu_decode = ALU_XOR;
      3'b101:  alu_decode = f7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

  assign is_load   = (op_i == OP_LOAD);
  assign mem_f3_ok = is_load ? (funct3_i == 3'b010 || funct3_i == 3'b100)
                             : (funct3_i == 3'b010 || funct3_i == 3'b000);
  assign byte_sel  = is_load ? (funct3_i == 3'b100) : (funct3_i == 3'b000);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= FETCH;
      exec_wb   <= 1'b0;
      instret_o <= '0;
      illegal_o <= 1'b0;
    end else begin
      state   <= next_state;
      exec_wb <= exec_wb_next;
      if (done_c) instret_o <= instret_o + DATA_WIDTH'(1);
      if (next_state == ILLEGAL) illegal_o <= 1'b1;
    end
  end

  always_comb begin
    next_state         = state;
    exec_wb_next       = 1'b0;
    ir_we_c            = 1'b0;
    pc_we_c            = 1'b0;
    reg_we_c           = 1'b0;
    dm_we_c            = 1'b0;
    done_c             = 1'b0;
    pc_src_o           = 2'b00;
    result_src_o       = 2'b00;
    alu_control_o      = ALU_ADD;
    alu_src_o          = 1'b0;
    data_mem_byte_op_o = 1'b0;
    case (state)
      FETCH: begin
        ir_we_c    = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        case (op_i)
          OP_R:               next_state = EXEC_R;
          OP_I:               next_state = EXEC_I;
          OP_LOAD, OP_STORE:  next_state = MEM_ADDR;
          OP_BRANCH:          next_state = BRANCH;
          OP_JAL:             next_state = JUMP;
          OP_JALR:            next_state = JALR;
          OP_LUI:             next_state = LUI;
          default:            next_state = ILLEGAL;
        endcase
      end
      EXEC_R, EXEC_I: begin
        alu_control_o = alu_decode(funct3_i, funct7_5_i, state == EXEC_R);
        alu_src_o     = (state == EXEC_I);
        if (exec_wb) begin
          reg_we_c   = 1'b1;
          pc_we_c    = 1'b1;
          done_c     = 1'b1;
          next_state = FETCH;
        end else begin
          exec_wb_next = 1'b1;
        end
      end
      MEM_ADDR: begin
        alu_src_o          = 1'b1;
        data_mem_byte_op_o = byte_sel;
        if (!mem_f3_ok)   next_state = ILLEGAL;
        else if (is_load) next_state = MEM_RD;
        else              next_state = MEM_WR;
      end
      MEM_RD: begin
        alu_src_o          = 1'b1;
        data_mem_byte_op_o = byte_sel;
        if (mem_ready_i) next_state = WB_MEM;
      end
      MEM_WR: begin
        alu_src_o          = 1'b1;
        data_mem_byte_op_o = byte_sel;
        dm_we_c            = 1'b1;
        if (mem_ready_i) begin
          pc_we_c    = 1'b1;
          done_c     = 1'b1;
          next_state = FETCH;
        end
      end
      WB_MEM: begin
        reg_we_c     = 1'b1;
        result_src_o = 2'b01;
        pc_we_c      = 1'b1;
        done_c       = 1'b1;
        next_state   = FETCH;
      end
      BRANCH: begin
        alu_control_o = ALU_SUB;
        if (funct3_i == 3'b000 || funct3_i == 3'b001) begin
          pc_we_c    = 1'b1;
          done_c     = 1'b1;
          pc_src_o   = (eq_i ^ funct3_i[0]) ? 2'b01 : 2'b00;
          next_state = FETCH;
        end else begin
          next_state = ILLEGAL;
        end
      end
      JUMP: begin
        reg_we_c     = 1'b1;
        result_src_o = 2'b10;
        pc_we_c      = 1'b1;
        pc_src_o     = 2'b01;
        done_c       = 1'b1;
        next_state   = FETCH;
      end
      JALR: begin
        alu_src_o    = 1'b1;
        reg_we_c     = 1'b1;
        result_src_o = 2'b10;
        pc_we_c      = 1'b1;
        pc_src_o     = 2'b10;
        done_c       = 1'b1;
        next_state   = FETCH;
      end
      LUI: begin
        reg_we_c     = 1'b1;
        result_src_o = 2'b11;
        pc_we_c      = 1'b1;
        done_c       = 1'b1;
        next_state   = FETCH;
      end
      ILLEGAL:  next_state = ILLEGAL;
      default:  next_state = FETCH;
    endcase
  end

  assign ir_we_o       = ir_we_c  & ~rst_i;
  assign pc_we_o       = pc_we_c  & ~rst_i;
  assign reg_we_o      = reg_we_c & ~rst_i;
  assign data_mem_we_o = dm_we_c  & ~rst_i;
  assign instr_done_o  = done_c   & ~rst_i;

endmodule

// File: tb/tb_multicycle_controller.sv
// Cycle-by-cycle vector bench for multicycle_controller (DATA_WIDTH=4 so instret wraps quickly).
module tb_multicycle_controller;

  localparam int DW = 4;
  localparam logic [6:0] OP_R   = 7'b0110011, OP_I   = 7'b0010011, OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011, OP_BR  = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111, OP_LUI = 7'b0110111, OP_BAD = 7'b1111111;

  // Expected bits: {ir_we, pc_we, reg_we, dm_we, pc_src[2], result_src[2], alu[4], alu_src, byte_op, done, illegal}
  typedef struct packed {
    logic          rst;
    logic [6:0]    op;
    logic [2:0]    f3;
    logic          f75;
    logic          eq;
    logic          mr;
    logic [16:0]   exp;
    logic [DW-1:0] inst;
  } vec_t;

  logic clk = 1'b0;
  logic rst_i, funct7_5_i, eq_i, mem_ready_i;
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic ir_we_o, pc_we_o, reg_we_o, data_mem_we_o, alu_src_o, data_mem_byte_op_o;
  logic instr_done_o, illegal_o;
  logic [1:0] pc_src_o, result_src_o;
  logic [3:0] alu_control_o;
  logic [DW-1:0] instret_o;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  multicycle_controller #(.DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .funct3_i(funct3_i), .funct7_5_i(funct7_5_i),
    .eq_i(eq_i), .mem_ready_i(mem_ready_i), .ir_we_o(ir_we_o), .pc_we_o(pc_we_o),
    .reg_we_o(reg_we_o), .data_mem_we_o(data_mem_we_o), .pc_src_o(pc_src_o),
    .result_src_o(result_src_o), .alu_control_o(alu_control_o), .alu_src_o(alu_src_o),
    .data_mem_byte_op_o(data_mem_byte_op_o), .instr_done_o(instr_done_o),
    .illegal_o(illegal_o), .instret_o(instret_o)
  );

  task automatic add(input logic rst, input logic [6:0] op, input logic [2:0] f3, input logic f75,
                     input logic eq, input logic mr, input logic [16:0] exp, input logic [DW-1:0] inst);
    vec_t v;
    v.rst = rst; v.op = op; v.f3 = f3; v.f75 = f75; v.eq = eq; v.mr = mr;
    v.exp = exp; v.inst = inst;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs after a falling edge, then check outputs mid-cycle.
  task automatic step(input string name, input vec_t v);
    logic [16:0] act;
    @(negedge clk);
    rst_i = v.rst; op_i = v.op; funct3_i = v.f3; funct7_5_i = v.f75; eq_i = v.eq; mem_ready_i = v.mr;
    #1;
    act = {ir_we_o, pc_we_o, reg_we_o, data_mem_we_o, pc_src_o, result_src_o, alu_control_o,
           alu_src_o, data_mem_byte_op_o, instr_done_o, illegal_o};
    checks++;
    if (act !== v.exp || instret_o !== v.inst) begin
      failures++;
      $display("FAIL %s: outputs=%b instret=%0d, expected outputs=%b instret=%0d",
               name, act, instret_o, v.exp, v.inst);
    end
  endtask

  // Emits the FETCH and DECODE rows shared by every instruction.
  task automatic fd(input logic [6:0] op, input logic [2:0] f3, input logic f75, input logic [DW-1:0] inst);
    add(0, op, f3, f75, 0, 0, 17'b1000_00_00_0000_0000, inst);
    add(0, op, f3, f75, 0, 0, 17'b0000_00_00_0000_0000, inst);
  endtask

  initial begin
    vec_t v;
    rst_i = 1'b1; op_i = '0; funct3_i = '0; funct7_5_i = 1'b0; eq_i = 1'b0; mem_ready_i = 1'b0;
    repeat (2) @(posedge clk);

    add(1, OP_R, 3'b000, 0, 0, 0, 17'b0000_00_00_0000_0000, 0);       // reset: strobes forced low
    fd(OP_R, 3'b000, 0, 0);                                             // ADD
    add(0, OP_R, 3'b000, 0, 0, 0, 17'b0000_00_00_0000_0000, 0);
    add(0, OP_R, 3'b000, 0, 0, 0, 17'b0110_00_00_0000_0010, 0);
    fd(OP_R, 3'b000, 1, 1);                                             // SUB
    add(0, OP_R, 3'b000, 1, 0, 0, 17'b0000_00_00_0001_0000, 1);
    add(0, OP_R, 3'b000, 1, 0, 0, 17'b0110_00_00_0001_0010, 1);
    fd(OP_I, 3'b000, 1, 2);                                             // ADDI with f7_5 set stays ADD
    add(0, OP_I, 3'b000, 1, 0, 0, 17'b0000_00_00_0000_1000, 2);
    add(0, OP_I, 3'b000, 1, 0, 0, 17'b0110_00_00_0000_1010, 2);
    fd(OP_I, 3'b101, 1, 3);                                             // SRAI
    add(0, OP_I, 3'b101, 1, 0, 0, 17'b0000_00_00_0111_1000, 3);
    add(0, OP_I, 3'b101, 1, 0, 0, 17'b0110_00_00_0111_1010, 3);
    fd(OP_R, 3'b111, 0, 4);                                             // AND
    add(0, OP_R, 3'b111, 0, 0, 0, 17'b0000_00_00_0010_0000, 4);
    add(0, OP_R, 3'b111, 0, 0, 0, 17'b0110_00_00_0010_0010, 4);
    fd(OP_LD, 3'b010, 0, 5);                                            // LW, two wait cycles
    add(0, OP_LD, 3'b010, 0, 0, 0, 17'b0000_00_00_0000_1000, 5);
    add(0, OP_LD, 3'b010, 0, 0, 0, 17'b0000_00_00_0000_1000, 5);
    add(0, OP_LD, 3'b010, 0, 0, 0, 17'b0000_00_00_0000_1000, 5);
    add(0, OP_LD, 3'b010, 0, 0, 1, 17'b0000_00_00_0000_1000, 5);
    add(0, OP_LD, 3'b010, 0, 0, 0, 17'b0110_00_01_0000_0010, 5);
    fd(OP_ST, 3'b000, 0, 6);                                            // SB, one wait cycle
    add(0, OP_ST, 3'b000, 0, 0, 0, 17'b0000_00_00_0000_1100, 6);
    add(0, OP_ST, 3'b000, 0, 0, 0, 17'b0001_00_00_0000_1100, 6);
    add(0, OP_ST, 3'b000, 0, 0, 1, 17'b0101_00_00_0000_1110, 6);
    fd(OP_BR, 3'b001, 0, 7);                                            // BNE not taken
    add(0, OP_BR, 3'b001, 0, 1, 0, 17'b0100_00_00_0001_0010, 7);
    fd(OP_BR, 3'b001, 0, 8);                                            // BNE taken
    add(0, OP_BR, 3'b001, 0, 0, 0, 17'b0100_01_00_0001_0010, 8);
    fd(OP_BR, 3'b000, 0, 9);                                            // BEQ taken
    add(0, OP_BR, 3'b000, 0, 1, 0, 17'b0100_01_00_0001_0010, 9);
    fd(OP_JAL, 3'b000, 0, 10);
    add(0, OP_JAL, 3'b000, 0, 0, 0, 17'b0110_01_10_0000_0010, 10);
    fd(OP_JR, 3'b000, 0, 11);
    add(0, OP_JR, 3'b000, 0, 0, 0, 17'b0110_10_10_0000_1010, 11);
    for (int k = 12; k < 18; k++) begin                                 // LUI x6: instret wraps 15 -> 0
      fd(OP_LUI, 3'b000, 0, DW'(k));
      add(0, OP_LUI, 3'b000, 0, 0, 0, 17'b0110_00_11_0000_0010, DW'(k));
    end
    fd(OP_ST, 3'b010, 0, 2);                                            // SW interrupted by reset
    add(0, OP_ST, 3'b010, 0, 0, 0, 17'b0000_00_00_0000_1000, 2);
    add(0, OP_ST, 3'b010, 0, 0, 0, 17'b0001_00_00_0000_1000, 2);
    add(1, OP_ST, 3'b010, 0, 0, 0, 17'b0000_00_00_0000_1000, 2);
    add(0, OP_ST, 3'b010, 0, 0, 0, 17'b1000_00_00_0000_0000, 0);

    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

    // Illegal opcode: trapped for 10 cycles, then cleared by reset.
    vecs.delete();
    add(0, OP_BAD, 3'b000, 0, 0, 0, 17'b0000_00_00_0000_0000, 0);       // DECODE
    v = vecs[0];
    step("illegal_decode", v);
    v.exp = 17'b0000_00_00_0000_0001;
    for (int c = 0; c < 10; c++) begin
      v.mr = c[0]; v.eq = c[1];
      step($sformatf("illegal_hold%0d", c), v);
    end
    v.rst = 1'b1; v.exp = 17'b0000_00_00_0000_0001;
    step("illegal_rst", v);
    v.rst = 1'b0; v.exp = 17'b1000_00_00_0000_0000;
    step("illegal_cleared", v);

    // Bad load width traps after MEM_ADDR.
    v.op = OP_LD; v.f3 = 3'b001; v.exp = 17'b0000_00_00_0000_0000;
    step("lbad_decode", v);
    v.exp = 17'b0000_00_00_0000_1000;
    step("lbad_memaddr", v);
    v.exp = 17'b0000_00_00_0000_0001; v.mr = 1'b1;
    step("lbad_illegal", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the retired-instruction counter.
REQ-002 Port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst_i, input, 1: reset, synchronous and active-high.
REQ-004 Port op_i, input, 7: opcode field of the held instruction register.
REQ-005 Port funct3_i, input, 3; funct7_5_i, input, 1: instruction fields.
REQ-006 Port eq_i, input, 1: ALU equality flag.
REQ-007 Port mem_ready_i, input, 1: data memory completes the access this cycle.
REQ-008 Port ir_we_o, output, 1; pc_we_o, output, 1; reg_we_o, output, 1; data_mem_we_o, output, 1: write strobes.
REQ-009 Port pc_src_o, output, 2: 00 = pc+4, 01 = pc+imm, 10 = ALU result.
REQ-010 Port result_src_o, output, 2: 00 = ALU, 01 = memory, 10 = pc_next, 11 = imm_ext.
REQ-011 Port alu_control_o, output, 4; alu_src_o, output, 1 (1 = immediate); data_mem_byte_op_o, output, 1.
REQ-012 Port instr_done_o, output, 1: pulse in the last cycle of each instruction; illegal_o, output, 1: sticky illegal flag.
REQ-013 Port instret_o, output, DATA_WIDTH: retired-instruction count.

Function
REQ-014 Outputs SHALL be Moore: decoded from the registered state plus op_i/funct fields.
REQ-015 States SHALL be FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, BRANCH, JUMP, JALR, LUI, ILLEGAL.
REQ-016 FETCH SHALL assert ir_we_o for 1 cycle and then go to DECODE.
REQ-017 DECODE SHALL dispatch on op_i as follows:
- 0110011 -> EXEC_R; 0010011 -> EXEC_I.
- 0000011 and 0100011 -> MEM_ADDR.
- 1100011 -> BRANCH; 1101111 -> JUMP; 1100111 -> JALR; 0110111 -> LUI.
- Any other opcode -> ILLEGAL.
REQ-018 ALU encodings SHALL be ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- The encoding is selected by funct3, with funct7_5_i choosing SUB or SRA.
- SUB is used only in EXEC_R; EXEC_I always uses ADD for funct3 000.
REQ-019 EXEC_R and EXEC_I SHALL be last states: reg_we_o=1, result_src_o=00, pc_we_o=1, pc_src_o=00; alu_src_o is 0 in EXEC_R and 1 in EXEC_I.
REQ-020 MEM_ADDR SHALL drive ADD with alu_src_o=1, then go to MEM_RD (load) or MEM_WR (store).
REQ-021 Loads SHALL accept funct3 010 (word) or 100 (byte, data_mem_byte_op_o=1); stores SHALL accept 010 or 000 (byte); any other funct3 SHALL go to ILLEGAL.
REQ-022 MEM_RD and MEM_WR SHALL hold the address and byte_op stable until mem_ready_i=1.
REQ-023 MEM_WR SHALL assert data_mem_we_o every cycle it is occupied.
- It SHALL be the last state when mem_ready_i=1 (pc_we_o=1, pc_src_o=00).
REQ-024 MEM_RD with mem_ready_i=1 SHALL go to WB_MEM; WB_MEM is the last state with reg_we_o=1, result_src_o=01, pc_we_o=1, pc_src_o=00.
REQ-025 BRANCH SHALL drive SUB with alu_src_o=0 and pc_we_o=1.
- pc_src_o=01 if taken, otherwise 00.
- Taken means eq_i=1 for funct3 000 and eq_i=0 for funct3 001; any other funct3 goes to ILLEGAL.
REQ-026 JUMP SHALL assert reg_we_o=1, result_src_o=10, pc_we_o=1, pc_src_o=01.
REQ-027 JALR SHALL drive ADD with alu_src_o=1 and assert reg_we_o=1, result_src_o=10, pc_we_o=1, pc_src_o=10.
REQ-028 LUI SHALL assert reg_we_o=1, result_src_o=11, pc_we_o=1, pc_src_o=00.
REQ-029 Every last state SHALL pulse instr_done_o, increment instret_o by 1 (wrapping from all-ones to 0), and return to FETCH.
REQ-030 In ILLEGAL, all write strobes SHALL be 0, illegal_o=1, and the state SHALL be held until reset.
REQ-031 Instruction latency SHALL be:
- R/I/LUI/JAL/JALR: 4, 4, 3, 3, 3 cycles.
- Branch: 3 cycles; store: 4+waits; load: 5+waits.
REQ-032 Outputs SHALL default to 0 in any state that does not drive them.

Reset
REQ-033 rst_i high at an edge SHALL force state=FETCH, instret_o=0, illegal_o=0, including mid-instruction and in MEM_WR while waiting.
REQ-034 While rst_i=1, ir_we_o, pc_we_o, reg_we_o and data_mem_we_o SHALL be forced to 0 combinationally.

Verification
REQ-035 ADD x (op 0110011, f3 000, f7_5 0) -> ir_we in cycle 1; cycle 4 shows reg_we=1, alu_control=0000, pc_src=00; instret 0->1.
REQ-036 LW with mem_ready_i low for 2 cycles -> MEM_RD is held 3 cycles; WB_MEM reg_we=1, result_src=01; total 7 cycles.
REQ-037 SB (f3 000), mem_ready after 1 wait -> data_mem_we=1 and byte_op=1 for 2 cycles; instr_done in the 2nd.
REQ-038 BNE with eq_i=1 then eq_i=0 -> pc_src=00, then 01; pc_we=1 both times; 3 cycles each.
REQ-039 op 1111111 -> ILLEGAL; illegal_o=1 and strobes 0 for 10 cycles; rst_i -> FETCH, illegal_o=0.
REQ-040 rst_i pulse during MEM_WR -> data_mem_we=0 that cycle; next state FETCH; instret_o=0.
